// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU trigger, work-RAM read and PPU OAM write signals of the sprite DMA
interface oam_dma_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  cpu_wr;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_din;
    logic                  rdy;
    logic                  dma_active;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  oam_wr;
    logic [7:0]            oam_addr;
    logic [DATA_WIDTH-1:0] oam_data;

    modport slave (
        input  cpu_wr, cpu_addr, cpu_din, mem_rd_data,
        output rdy, dma_active, mem_addr, oam_wr, oam_addr, oam_data
    );

    modport master (
        output cpu_wr, cpu_addr, cpu_din, mem_rd_data,
        input  rdy, dma_active, mem_addr, oam_wr, oam_addr, oam_data
    );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: copies one CPU page into PPU OAM, alternating RAM read and OAM write cycles
module oam_dma #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR = 16'h4014,
    parameter int                    XFER_LEN     = 256
) (
    input logic         clk,
    input logic         rst,
    oam_dma_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, HALT, READ, WRITE} state_t;

    localparam logic [7:0] LAST = 8'(XFER_LEN - 1);

    state_t     state, state_n;
    logic [7:0] page, page_n, idx, idx_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            page  <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            page  <= page_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        page_n  = page;
        idx_n   = idx;
        case (state)
            IDLE:
                if (bus.cpu_wr && bus.cpu_addr == DMA_REG_ADDR) begin
                    page_n  = bus.cpu_din[7:0];
                    idx_n   = '0;
                    state_n = HALT;
                end
            HALT: state_n = READ;
            READ: state_n = WRITE;
            WRITE: begin
                idx_n   = (idx == LAST) ? 8'd0 : idx + 8'd1;
                state_n = (idx == LAST) ? IDLE : READ;
            end
            default: state_n = IDLE;
        endcase
    end

    // RAM registers its address, so holding it through WRITE keeps mem_rd_data valid there
    assign bus.rdy        = (state == IDLE);
    assign bus.dma_active = (state != IDLE);
    assign bus.mem_addr   = (state == READ || state == WRITE) ? ADDR_WIDTH'({page, idx}) : '0;
    assign bus.oam_wr     = (state == WRITE);
    assign bus.oam_addr   = (state == WRITE) ? idx : 8'd0;
    assign bus.oam_data   = (state == WRITE) ? bus.mem_rd_data : {DATA_WIDTH{1'b0}};
endmodule
